regfile_2r1w: RTL and testbench

- Next-generation CPU register file.
- Parametrised depth and width, two synchronous read ports, one byte-masked write port, optional same-cycle write-to-read bypass, optional hardwired-zero R0.
- Contents are cleared by a sequential clear engine after reset, so no async reset on storage; maps to distributed/block RAM.
- Sits between decode (read addresses) and writeback (write port); busy stalls the pipeline until clear completes.

---
 rtl/regfile_2r1w_if.sv | 27 ++
 rtl/regfile_2r1w.sv | 123 ++++++++++++
 tb/tb_regfile_2r1w.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_2r1w_if.sv
// Decode/writeback bundle for the 2R1W register file: one byte-masked write port,
// two registered read ports, and the clear-engine status strobes.
interface regfile_2r1w_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                    we;
    logic [ADDR_WIDTH-1:0]   wadr;
    logic [DATA_WIDTH/8-1:0] wbe;
    logic [DATA_WIDTH-1:0]   din;
    logic [ADDR_WIDTH-1:0]   radr1;
    logic [ADDR_WIDTH-1:0]   radr2;
    logic [DATA_WIDTH-1:0]   dout1;
    logic [DATA_WIDTH-1:0]   dout2;
    logic                    busy;
    logic                    wr_pulse;

    modport master (
        output we, wadr, wbe, din, radr1, radr2,
        input  dout1, dout2, busy, wr_pulse
    );

    modport slave (
        input  we, wadr, wbe, din, radr1, radr2,
        output dout1, dout2, busy, wr_pulse
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with byte-masked writes, optional write-to-read
// bypass and hardwired-zero R0; storage is zeroed by a clear engine after reset.
module regfile_2r1w #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          ZERO_R0    = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    regfile_2r1w_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
        $error("regfile_2r1w: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout1;
    logic [DATA_WIDTH-1:0] r_dout2;
    logic                  r_busy;
    logic                  r_wr_pulse;

    logic                  w_wr_ok;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_adr;
    logic [LANES-1:0]      w_mem_be;
    logic [DATA_WIDTH-1:0] w_mem_din;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // Read value for one port: old contents, optionally merged with a same-cycle write.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] adr,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic                  wr_ok,
        input logic [ADDR_WIDTH-1:0] wadr,
        input logic [LANES-1:0]      wbe,
        input logic [DATA_WIDTH-1:0] din
    );
        logic [DATA_WIDTH-1:0] v;
        v = old_word;
        if (BYPASS && wr_ok && (adr == wadr)) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wbe[i]) v[8*i +: 8] = din[8*i +: 8];
            end
        end
        if (ZERO_R0 && (adr == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        w_wr_ok = (r_state == StReady) && bus.we && (bus.wbe != '0)
                  && !(ZERO_R0 && (bus.wadr == '0));
        if (r_state == StClear) begin
            w_mem_we  = 1'b1;
            w_mem_adr = r_clr_ptr;
            w_mem_be  = '1;
            w_mem_din = '0;
        end else begin
            w_mem_we  = w_wr_ok;
            w_mem_adr = bus.wadr;
            w_mem_be  = bus.wbe;
            w_mem_din = bus.din;
        end
        w_rd1 = read_port(bus.radr1, r_mem[bus.radr1], w_wr_ok, bus.wadr, bus.wbe, bus.din);
        w_rd2 = read_port(bus.radr2, r_mem[bus.radr2], w_wr_ok, bus.wadr, bus.wbe, bus.din);
    end

    // No reset on storage so it can map onto RAM; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (w_mem_be[i]) r_mem[w_mem_adr][8*i +: 8] <= w_mem_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StClear;
            r_clr_ptr  <= '0;
            r_dout1    <= '0;
            r_dout2    <= '0;
            r_busy     <= 1'b1;
            r_wr_pulse <= 1'b0;
        end else begin
            unique case (r_state)
                StClear: begin
                    r_clr_ptr  <= r_clr_ptr + 1'b1;
                    r_dout1    <= '0;
                    r_dout2    <= '0;
                    r_wr_pulse <= 1'b0;
                    if (r_clr_ptr == '1) begin
                        r_state <= StReady;
                        r_busy  <= 1'b0;
                    end
                end
                StReady: begin
                    r_dout1    <= w_rd1;
                    r_dout2    <= w_rd2;
                    r_wr_pulse <= w_wr_ok;
                end
                default: begin
                    r_state   <= StClear;
                    r_clr_ptr <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dout1    = r_dout1;
    assign bus.dout2    = r_dout2;
    assign bus.busy     = r_busy;
    assign bus.wr_pulse = r_wr_pulse;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed-vector bench: a bypassing and a non-bypassing/zero-R0 instance share stimulus;
// a wider instance is checked against a scoreboard with random traffic.
module tb_regfile_2r1w;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;

    regfile_2r1w_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if_a ();
    regfile_2r1w_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if_b ();
    regfile_2r1w_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) if_c ();

    regfile_2r1w #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    regfile_2r1w #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYPASS(1'b0), .ZERO_R0(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );
    regfile_2r1w #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut_c (
        .clk(clk), .reset(reset), .bus(if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  wadr;
        logic [1:0]  wbe;
        logic [15:0] din;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic        a_wp;
        logic [15:0] a_d1;
        logic [15:0] a_d2;
        logic        b_wp;
        logic [15:0] b_d1;
        logic [15:0] b_d2;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic we, input logic [3:0] wadr, input logic [1:0] wbe,
                            input logic [15:0] din, input logic [3:0] r1, input logic [3:0] r2);
        if_a.we = we; if_a.wadr = wadr; if_a.wbe = wbe; if_a.din = din;
        if_a.radr1 = r1; if_a.radr2 = r2;
        if_b.we = we; if_b.wadr = wadr; if_b.wbe = wbe; if_b.din = din;
        if_b.radr1 = r1; if_b.radr2 = r2;
    endtask

    // Counts edges until busy drops; outputs must stay quiet the whole time.
    task automatic wait_clear(input string nm, input int exp_cnt);
        int   cnt;
        logic bad;
        cnt = 0;
        bad = 1'b0;
        while (if_a.busy && cnt < 64) begin
            tick();
            cnt++;
            if (if_a.wr_pulse || if_b.wr_pulse || (if_a.dout1 != 16'h0) || (if_a.dout2 != 16'h0)
                || (if_b.dout1 != 16'h0) || (if_b.dout2 != 16'h0)) bad = 1'b1;
        end
        chk({nm, " busy_cycles"}, 32'(cnt), 32'(exp_cnt));
        chk({nm, " quiet_while_busy"}, 32'(bad), 32'd0);
        chk({nm, " b_busy_done"}, 32'(if_b.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] mem_c [32];
        logic [31:0] e1, e2;
        logic        acc;

        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b0;
        drive_ab(1'b0, 4'd0, 2'b00, 16'h0, 4'd0, 4'd0);
        if_c.we = 1'b0; if_c.wadr = '0; if_c.wbe = '0; if_c.din = '0;
        if_c.radr1 = '0; if_c.radr2 = '0;

        vecs[0]  = '{1'b1, 4'd3,  2'b11, 16'hABCD, 4'd3,  4'd3,  1'b1, 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 4'd3,  2'b01, 16'h1234, 4'd3,  4'd4,  1'b1, 16'hAB34, 16'h0000, 1'b1, 16'hABCD, 16'h0000};
        vecs[2]  = '{1'b0, 4'd3,  2'b11, 16'h0000, 4'd3,  4'd3,  1'b0, 16'hAB34, 16'hAB34, 1'b0, 16'hAB34, 16'hAB34};
        vecs[3]  = '{1'b1, 4'd5,  2'b11, 16'h0001, 4'd5,  4'd0,  1'b1, 16'h0001, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b1, 4'd5,  2'b11, 16'h5555, 4'd5,  4'd5,  1'b1, 16'h5555, 16'h5555, 1'b1, 16'h0001, 16'h0001};
        vecs[5]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 4'd5,  4'd5,  1'b0, 16'h5555, 16'h5555, 1'b0, 16'h5555, 16'h5555};
        vecs[6]  = '{1'b1, 4'd0,  2'b11, 16'hBEEF, 4'd0,  4'd0,  1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 4'd0,  4'd3,  1'b0, 16'hBEEF, 16'hAB34, 1'b0, 16'h0000, 16'hAB34};
        vecs[8]  = '{1'b1, 4'd3,  2'b00, 16'hFFFF, 4'd3,  4'd3,  1'b0, 16'hAB34, 16'hAB34, 1'b0, 16'hAB34, 16'hAB34};
        vecs[9]  = '{1'b1, 4'd7,  2'b10, 16'h9900, 4'd7,  4'd6,  1'b1, 16'h9900, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 4'd0,  2'b00, 16'h0000, 4'd7,  4'd5,  1'b0, 16'h9900, 16'h5555, 1'b0, 16'h9900, 16'h5555};
        vecs[11] = '{1'b1, 4'd15, 2'b11, 16'hCAFE, 4'd15, 4'd14, 1'b1, 16'hCAFE, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        vecs[12] = '{1'b0, 4'd0,  2'b00, 16'h0000, 4'd15, 4'd0,  1'b0, 16'hCAFE, 16'hBEEF, 1'b0, 16'hCAFE, 16'h0000};

        // Reset values
        #12;
        chk("rst a_busy", 32'(if_a.busy), 32'd1);
        chk("rst a_dout1", 32'(if_a.dout1), 32'd0);
        chk("rst a_dout2", 32'(if_a.dout2), 32'd0);
        chk("rst a_wr_pulse", 32'(if_a.wr_pulse), 32'd0);
        chk("rst b_busy", 32'(if_b.busy), 32'd1);
        chk("rst c_busy", 32'(if_c.busy), 32'd1);

        // First clear with a write request pending against r2
        @(negedge clk);
        drive_ab(1'b1, 4'd2, 2'b11, 16'h7777, 4'd2, 4'd2);
        reset = 1'b1;
        wait_clear("clear1", 16);

        // Fill every entry with FFFF
        for (int i = 0; i < 16; i++) begin
            drive_ab(1'b1, 4'(i), 2'b11, 16'hFFFF, 4'(i), 4'(i));
            tick();
            chk($sformatf("fill%0d a_wr_pulse", i), 32'(if_a.wr_pulse), 32'd1);
            chk($sformatf("fill%0d b_wr_pulse", i), 32'(if_b.wr_pulse), (i == 0) ? 32'd0 : 32'd1);
        end

        // Mid-run reset pulse with a request held on the bus during the clear
        drive_ab(1'b1, 4'd2, 2'b11, 16'h7777, 4'd2, 4'd2);
        #2 reset = 1'b0;
        #1;
        chk("midrun a_busy_async", 32'(if_a.busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        wait_clear("clear2", 16);

        // Reset again while clr_ptr sits at 7
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (7) tick();
        chk("midclear a_busy", 32'(if_a.busy), 32'd1);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_clear("clear3", 16);

        // Every entry must read zero on both ports
        for (int i = 0; i < 16; i++) begin
            drive_ab(1'b0, 4'd0, 2'b00, 16'h0, 4'(i), 4'(15 - i));
            tick();
            chk($sformatf("zero%0d a_dout1", i), 32'(if_a.dout1), 32'd0);
            chk($sformatf("zero%0d a_dout2", i), 32'(if_a.dout2), 32'd0);
            chk($sformatf("zero%0d b_dout1", i), 32'(if_b.dout1), 32'd0);
            chk($sformatf("zero%0d b_dout2", i), 32'(if_b.dout2), 32'd0);
        end

        // Directed table
        for (int v = 0; v < 13; v++) begin
            drive_ab(vecs[v].we, vecs[v].wadr, vecs[v].wbe, vecs[v].din, vecs[v].r1, vecs[v].r2);
            tick();
            chk($sformatf("vec%0d a_wr_pulse", v), 32'(if_a.wr_pulse), 32'(vecs[v].a_wp));
            chk($sformatf("vec%0d a_dout1", v), 32'(if_a.dout1), 32'(vecs[v].a_d1));
            chk($sformatf("vec%0d a_dout2", v), 32'(if_a.dout2), 32'(vecs[v].a_d2));
            chk($sformatf("vec%0d b_wr_pulse", v), 32'(if_b.wr_pulse), 32'(vecs[v].b_wp));
            chk($sformatf("vec%0d b_dout1", v), 32'(if_b.dout1), 32'(vecs[v].b_d1));
            chk($sformatf("vec%0d b_dout2", v), 32'(if_b.dout2), 32'(vecs[v].b_d2));
        end
        drive_ab(1'b0, 4'd0, 2'b00, 16'h0, 4'd0, 4'd0);

        // Random traffic on the 32x32 instance against a scoreboard
        chk("c_ready", 32'(if_c.busy), 32'd0);
        for (int i = 0; i < 32; i++) mem_c[i] = 32'h0;
        for (int n = 0; n < 300; n++) begin
            if_c.we    = ($urandom_range(0, 3) != 0);
            if_c.wadr  = 5'($urandom_range(0, 31));
            if_c.wbe   = 4'($urandom_range(0, 15));
            if_c.din   = $urandom;
            if_c.radr1 = ($urandom_range(0, 2) == 0) ? if_c.wadr : 5'($urandom_range(0, 31));
            if_c.radr2 = ($urandom_range(0, 2) == 0) ? if_c.wadr : 5'($urandom_range(0, 31));
            acc = if_c.we && (if_c.wbe != 4'h0);
            e1  = mem_c[if_c.radr1];
            e2  = mem_c[if_c.radr2];
            if (acc) begin
                for (int l = 0; l < 4; l++) begin
                    if (if_c.wbe[l]) begin
                        if (if_c.radr1 == if_c.wadr) e1[8*l +: 8] = if_c.din[8*l +: 8];
                        if (if_c.radr2 == if_c.wadr) e2[8*l +: 8] = if_c.din[8*l +: 8];
                        mem_c[if_c.wadr][8*l +: 8] = if_c.din[8*l +: 8];
                    end
                end
            end
            tick();
            chk($sformatf("rnd%0d c_dout1", n), if_c.dout1, e1);
            chk($sformatf("rnd%0d c_dout2", n), if_c.dout2, e2);
            chk($sformatf("rnd%0d c_wr_pulse", n), 32'(if_c.wr_pulse), 32'(acc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
